lfsr_stream_checker: RTL and testbench
======================================

# lfsr_stream_checker

- AXI-Stream slave sink that consumes the 8-bit LFSR stream from the team's LFSR generator and checks every beat against a locally generated reference sequence.
- Seed and taps are programmed over an AXI-Lite slave, with the same register conventions as the generator.
- Beat and error counts, lock status and the last mismatch are readable over the same AXI-Lite slave.
- Sits at the far end of the generator's stream link, in loopback or link-integrity tests.

## Interface
- C_AXIL_ADDR_WIDTH, 5, AXI-Lite address width (byte addresses 0x00–0x1C).
- C_AXIL_DATA_WIDTH, 32, AXI-Lite and AXI-Stream data width.
- aclk  in  1  sole clock; everything on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axi_awaddr/awvalid/awready  in/in/out  ADDR/1/1  write address.
- s_axi_wdata/wvalid/wready  in/in/out  DATA/1/1  write data (no strobes; full-word writes).
- s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response.
- s_axi_araddr/arvalid/arready  in/in/out  ADDR/1/1  read address.
- s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA/2/1/1  read data.
- s_axis_tdata  in  DATA  stream beat; bits [7:0] are LFSR value, upper bits must be 0.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  registered; high exactly while running.

## Operation
**Register map** (unmapped reads return 0; writes to RO or unmapped addresses are ignored; all responses OKAY):
- 0x00 CTRL (WO, self-clearing):
  - bit0 start: expected ← SEED, running ← 1.
  - bit1 stop: running ← 0.
  - bit2 clear: RX_COUNT, ERR_COUNT, LAST_BAD, error, locked and run counter ← 0.
- 0x04 STATUS (RO): bit0 running, bit1 locked, bit2 error (sticky until clear).
- 0x08 SEED (RW, 8b, reset 0x01).
- 0x0C TAPS (RW, 8b, reset 0xB4).
- 0x10 RX_COUNT (RO, 32b, wraps).
- 0x14 ERR_COUNT (RO, 32b, saturates at 0xFFFFFFFF).
- 0x18 LAST_BAD (RO): [15:8] expected, [7:0] received at most recent mismatch.

**Beat check** on every accepted beat (tvalid & tready):
- RX_COUNT increments.
- Match means tdata[7:0] == expected and tdata[DATA-1:8] == 0.
- Mismatch:
  - ERR_COUNT increments.
  - error ← 1.
  - LAST_BAD captured.
  - locked ← 0 and run counter ← 0.
- Match: run counter (4b) increments, saturating at 8; locked ← 1 when it reaches 8.
- Next expected = {e[6:0], ^(e & TAPS)}, where e is the current expected value (see Configuration).

**Simultaneous and boundary events:**
- Start while running reloads expected from SEED; counters are kept.
- Start and stop in the same CTRL write: stop wins.
- Clear in the same cycle as an accepted beat: clear wins and the beat is not counted.
- SEED/TAPS writes while running: TAPS takes effect on the next beat; SEED takes effect only at the next start.
- Reset mid-transfer: all state to reset values, s_axis_tready low the following cycle.

## Timing
**Reset values:**
- awready, wready, arready, bvalid, rvalid, s_axis_tready = 0.
- bresp, rresp = 0; rdata = 0.
- running, locked and error = 0; counters = 0.

**AXI-Lite write:**
- When awvalid & wvalid are both high and bvalid is low, awready and wready pulse high together for one cycle, starting the cycle after.
- The register update happens at that handshake edge.
- bvalid rises the next cycle and holds until bready.
- Only one write is outstanding at a time.

**AXI-Lite read:**
- When arvalid is high and rvalid is low, arready pulses one cycle later.
- rvalid and rdata follow one cycle after the handshake and hold until rready.
- A read of STATUS or counters returns the value sampled at the arvalid/arready edge.

**AXI-Stream:**
- s_axis_tready rises the cycle after the start handshake and falls the cycle after the stop handshake.
- Zero-bubble: one beat per cycle while tvalid is held.
- STATUS and counters reflect a beat one cycle after its acceptance edge.

## Configuration
- Macro: LFSR_CHK_RESYNC_EN.
- Defined: e in the next-expected equation is the received tdata[7:0], not the local expected value. The checker self-synchronizes, so a single corrupted beat produces two errors and it then realigns; after a slip it relocks within 8 good beats.
- Undefined: e is the local expected value, regardless of what was received. A single corrupted beat produces exactly one error; a slipped stream errors on every beat.

## Test plan
- Reset, then read 0x04/0x08/0x0C -> 0x0, 0x01, 0xB4; s_axis_tready = 0.
- Write CTRL=0x1, then stream 0x01,0x02,0x04,0x09,0x12,0x25 -> ERR_COUNT 0, RX_COUNT 6. Continue to 8 good beats -> STATUS = 0x3.
- Stream 0x01,0x02,0xFF,0x09:
  - Without the macro -> ERR_COUNT 1, LAST_BAD = 0x04FF, STATUS.error = 1.
  - With the macro -> ERR_COUNT 2.
- Beat 0x00000101 when 0x01 is expected -> counted as a mismatch (nonzero upper bits).
- CTRL write 0x3 (start and stop together) -> running stays 0. CTRL=0x4 in the same cycle as a beat -> RX_COUNT reads 0.
- Assert areset while a stream is mid-transfer and a bvalid is pending -> all outputs at reset values the next cycle; stream resumes only after a new start.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker
//   AXI-Stream sink that checks an 8-bit LFSR stream against a locally
//   generated reference. Seed/taps are programmed over AXI-Lite. Beat and
//   error counts, lock/error status and the last mismatch read back over
//   the same AXI-Lite slave.
//
//   Optional feature macro: LFSR_CHK_RESYNC_EN
//     defined   : next expected is derived from the received byte (self-sync)
//     undefined : next expected is derived from the local expected byte
//
// Ports
//   aclk, areset           clock, synchronous active-high reset
//   s_axi_aw*/w*/b*        AXI-Lite write (full-word writes, OKAY responses)
//   s_axi_ar*/r*           AXI-Lite read
//   s_axis_tdata/tvalid    stream beat in ([7:0] LFSR value, upper bits 0)
//   s_axis_tready          registered, high exactly while running
//
// Register map: 0x00 CTRL(WO) 0x04 STATUS 0x08 SEED 0x0C TAPS
//               0x10 RX_COUNT 0x14 ERR_COUNT 0x18 LAST_BAD
module lfsr_stream_checker #(
  parameter int C_AXIL_ADDR_WIDTH = 5,
  parameter int C_AXIL_DATA_WIDTH = 32
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [C_AXIL_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [C_AXIL_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [C_AXIL_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic [C_AXIL_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready
);
  localparam int DW = C_AXIL_DATA_WIDTH;
  localparam int RW = C_AXIL_ADDR_WIDTH - 2;   // word-index width
  localparam logic [RW-1:0] A_CTRL   = RW'(0);
  localparam logic [RW-1:0] A_STATUS = RW'(1);
  localparam logic [RW-1:0] A_SEED   = RW'(2);
  localparam logic [RW-1:0] A_TAPS   = RW'(3);
  localparam logic [RW-1:0] A_RXCNT  = RW'(4);
  localparam logic [RW-1:0] A_ERRCNT = RW'(5);
  localparam logic [RW-1:0] A_LASTBD = RW'(6);

  logic [7:0]  seed, taps, expected;
  logic        locked, error;
  logic [3:0]  run_cnt;
  logic [31:0] rx_count, err_count;
  logic [15:0] last_bad;

  logic          wr_en, rd_en, accept, match;
  logic [RW-1:0] wa, ra;
  logic          ctrl_wr, start, stop, clear;
  logic [7:0]    e_src, next_exp;
  logic [DW-1:0] rd_mux;
  logic          unused_bits;

  assign wa      = s_axi_awaddr[C_AXIL_ADDR_WIDTH-1:2];
  assign ra      = s_axi_araddr[C_AXIL_ADDR_WIDTH-1:2];
  assign wr_en   = s_axi_awready & s_axi_awvalid & s_axi_wready & s_axi_wvalid;
  assign rd_en   = s_axi_arready & s_axi_arvalid;
  assign accept  = s_axis_tvalid & s_axis_tready;
  assign ctrl_wr = wr_en && (wa == A_CTRL);
  assign stop    = ctrl_wr & s_axi_wdata[1];
  assign start   = ctrl_wr & s_axi_wdata[0] & ~s_axi_wdata[1];  // stop wins
  assign clear   = ctrl_wr & s_axi_wdata[2];

  assign match = (s_axis_tdata[7:0] == expected) && (s_axis_tdata[DW-1:8] == '0);
`ifdef LFSR_CHK_RESYNC_EN
  assign e_src = s_axis_tdata[7:0];
`else
  assign e_src = expected;
`endif
  assign next_exp = {e_src[6:0], ^(e_src & taps)};

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_comb begin
    rd_mux = '0;
    case (ra)
      A_STATUS: rd_mux = DW'({error, locked, s_axis_tready});
      A_SEED:   rd_mux = DW'(seed);
      A_TAPS:   rd_mux = DW'(taps);
      A_RXCNT:  rd_mux = DW'(rx_count);
      A_ERRCNT: rd_mux = DW'(err_count);
      A_LASTBD: rd_mux = DW'(last_bad);
      default:  rd_mux = '0;
    endcase
  end

  // AXI-Lite handshakes and programmable registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      seed          <= 8'h01;
      taps          <= 8'hB4;
    end else begin
      // one-cycle ready pulse; blocked while a response is outstanding
      s_axi_awready <= ~s_axi_awready & ~s_axi_bvalid & s_axi_awvalid & s_axi_wvalid;
      s_axi_wready  <= ~s_axi_awready & ~s_axi_bvalid & s_axi_awvalid & s_axi_wvalid;
      if (wr_en)             s_axi_bvalid <= 1'b1;
      else if (s_axi_bready) s_axi_bvalid <= 1'b0;
      s_axi_arready <= ~s_axi_arready & ~s_axi_rvalid & s_axi_arvalid;
      if (rd_en) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_mux;
      end else if (s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
      if (wr_en && wa == A_SEED) seed <= s_axi_wdata[7:0];
      if (wr_en && wa == A_TAPS) taps <= s_axi_wdata[7:0];
    end
  end

  // Run control and beat checking
  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axis_tready <= 1'b0;
      expected      <= 8'h00;
      locked        <= 1'b0;
      error         <= 1'b0;
      run_cnt       <= 4'd0;
      rx_count      <= '0;
      err_count     <= '0;
      last_bad      <= '0;
    end else begin
      if (stop)       s_axis_tready <= 1'b0;
      else if (start) s_axis_tready <= 1'b1;

      // start reloads the reference even if a beat lands on the same edge
      if (start)       expected <= seed;
      else if (accept) expected <= next_exp;

      if (clear) begin
        rx_count  <= '0;
        err_count <= '0;
        last_bad  <= '0;
        error     <= 1'b0;
        locked    <= 1'b0;
        run_cnt   <= 4'd0;
      end else if (accept) begin
        rx_count <= rx_count + 32'd1;
        if (match) begin
          if (run_cnt != 4'd8) run_cnt <= run_cnt + 4'd1;
          if (run_cnt == 4'd7) locked  <= 1'b1;
        end else begin
          if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
          error    <= 1'b1;
          last_bad <= {expected, s_axis_tdata[7:0]};
          locked   <= 1'b0;
          run_cnt  <= 4'd0;
        end
      end
    end
  end
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker. Seed 0x01 / taps 0xB4 give the
// reference sequence 01 02 04 09 12 25 4A 94 29 ...
module tb_lfsr_stream_checker;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = '0, tdata = '0;
  logic        tvalid = 0;
  logic        awready, wready, bvalid, arready, rvalid, tready;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  always #5 aclk = ~aclk;

  lfsr_stream_checker #(.C_AXIL_ADDR_WIDTH(5), .C_AXIL_DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready)
  );

  task automatic wait_awready();
    int n = 0;
    while (!awready && n < 20) begin @(posedge aclk); #1; n++; end
    if (!awready) begin errors++; checks++; $display("FAIL awready_timeout got 0 exp 1"); end
  endtask

  task automatic finish_write();
    int n = 0;
    while (!bvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!bvalid) begin errors++; checks++; $display("FAIL bvalid_timeout got 0 exp 1"); end
    bready = 1; @(posedge aclk); #1; bready = 0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge aclk); #1;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    wait_awready();
    @(posedge aclk); #1;                // handshake edge
    awvalid = 0; wvalid = 0;
    finish_write();
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
    int n = 0;
    @(posedge aclk); #1;
    araddr = a; arvalid = 1;
    while (!arready && n < 20) begin @(posedge aclk); #1; n++; end
    if (!arready) begin errors++; checks++; $display("FAIL arready_timeout got 0 exp 1"); end
    @(posedge aclk); #1;
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge aclk); #1; n++; end
    if (!rvalid) begin errors++; checks++; $display("FAIL rvalid_timeout got 0 exp 1"); end
    d = rdata;
    rready = 1; @(posedge aclk); #1; rready = 0;
  endtask

  // back-to-back calls keep tvalid continuously high (zero bubble)
  task automatic send_beat(input logic [31:0] d);
    tdata = d; tvalid = 1;
    @(posedge aclk); #1;
    tvalid = 0;
  endtask

  task automatic test_reset();
    areset = 1;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, tready} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 000000", {awready, wready, arready, bvalid, rvalid, tready});
    end
    checks++;
    if ({bresp, rresp, rdata} !== 36'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {bresp, rresp, rdata});
    end
    areset = 0;
    axi_read(5'h04, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", rd); end
    axi_read(5'h08, rd); checks++;
    if (rd !== 32'h01) begin errors++; $display("FAIL reset_seed got %h exp 01", rd); end
    axi_read(5'h0C, rd); checks++;
    if (rd !== 32'hB4) begin errors++; $display("FAIL reset_taps got %h exp b4", rd); end
    axi_read(5'h1C, rd); checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", rd); end
  endtask

  task automatic test_stream();
    axi_write(5'h00, 32'h1);
    checks++;
    if (tready !== 1'b1) begin errors++; $display("FAIL start_tready got %b exp 1", tready); end
    send_beat(32'h01); send_beat(32'h02); send_beat(32'h04);
    send_beat(32'h09); send_beat(32'h12); send_beat(32'h25);
    axi_read(5'h14, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL stream_err got %0d exp 0", rd); end
    axi_read(5'h10, rd); checks++;
    if (rd !== 32'd6) begin errors++; $display("FAIL stream_rx got %0d exp 6", rd); end
    axi_read(5'h04, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL prelock_status got %h exp 1", rd); end
    send_beat(32'h4A); send_beat(32'h94);
    axi_read(5'h04, rd); checks++;
    if (rd !== 32'h3) begin errors++; $display("FAIL locked_status got %h exp 3", rd); end
    axi_read(5'h10, rd); checks++;
    if (rd !== 32'd8) begin errors++; $display("FAIL locked_rx got %0d exp 8", rd); end
  endtask

  task automatic test_mismatch();
    logic [31:0] exp_err, exp_lb;
`ifdef LFSR_CHK_RESYNC_EN
    exp_err = 32'd2; exp_lb = 32'hFE09;
`else
    exp_err = 32'd1; exp_lb = 32'h04FF;
`endif
    axi_write(5'h00, 32'h5);            // clear + restart
    send_beat(32'h01); send_beat(32'h02); send_beat(32'hFF); send_beat(32'h09);
    axi_read(5'h14, rd); checks++;
    if (rd !== exp_err) begin errors++; $display("FAIL mismatch_err got %0d exp %0d", rd, exp_err); end
    axi_read(5'h18, rd); checks++;
    if (rd !== exp_lb) begin errors++; $display("FAIL mismatch_lastbad got %h exp %h", rd, exp_lb); end
    axi_read(5'h04, rd); checks++;
    if (rd !== 32'h5) begin errors++; $display("FAIL mismatch_status got %h exp 5", rd); end
  endtask

  task automatic test_upper_bits();
    axi_write(5'h00, 32'h5);
    send_beat(32'h0000_0101);
    axi_read(5'h14, rd); checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL upper_err got %0d exp 1", rd); end
    axi_read(5'h18, rd); checks++;
    if (rd !== 32'h0101) begin errors++; $display("FAIL upper_lastbad got %h exp 0101", rd); end
    axi_read(5'h10, rd); checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL upper_rx got %0d exp 1", rd); end
  endtask

  task automatic test_ctrl();
    axi_write(5'h00, 32'h2);
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL stop_tready got %b exp 0", tready); end
    axi_write(5'h00, 32'h3);            // start and stop together
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL startstop_tready got %b exp 0", tready); end
    axi_read(5'h04, rd); checks++;
    if (rd !== 32'h4) begin errors++; $display("FAIL startstop_status got %h exp 4", rd); end
  endtask

  task automatic test_clear_beat();
    axi_write(5'h00, 32'h1);            // restart, counters kept
    send_beat(32'h01);
    axi_read(5'h10, rd); checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL restart_rx got %0d exp 2", rd); end
    @(posedge aclk); #1;
    awaddr = 5'h00; wdata = 32'h4; awvalid = 1; wvalid = 1;
    wait_awready();
    tdata = 32'h02; tvalid = 1;         // beat lands on the clear handshake edge
    @(posedge aclk); #1;
    tvalid = 0; awvalid = 0; wvalid = 0;
    finish_write();
    axi_read(5'h10, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL clearbeat_rx got %0d exp 0", rd); end
    axi_read(5'h14, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL clearbeat_err got %0d exp 0", rd); end
    axi_read(5'h04, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL clearbeat_status got %h exp 1", rd); end
  endtask

  task automatic test_reset_mid();
    tdata = 32'h04; tvalid = 1;         // stream held mid-transfer
    awaddr = 5'h08; wdata = 32'h55; awvalid = 1; wvalid = 1;
    wait_awready();
    @(posedge aclk); #1;
    awvalid = 0; wvalid = 0;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL pending_bvalid got %b exp 1", bvalid); end
    areset = 1;
    @(posedge aclk); #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, tready} !== 6'b0) begin
      errors++; $display("FAIL midreset_outputs got %b exp 000000", {awready, wready, arready, bvalid, rvalid, tready});
    end
    areset = 0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (tready !== 1'b0) begin errors++; $display("FAIL postreset_tready got %b exp 0", tready); end
    tvalid = 0;
    axi_read(5'h08, rd); checks++;
    if (rd !== 32'h01) begin errors++; $display("FAIL postreset_seed got %h exp 01", rd); end
    axi_read(5'h10, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL postreset_rx got %0d exp 0", rd); end
    axi_write(5'h00, 32'h1);
    send_beat(32'h01); send_beat(32'h02);
    axi_read(5'h10, rd); checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL resume_rx got %0d exp 2", rd); end
    axi_read(5'h14, rd); checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL resume_err got %0d exp 0", rd); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mismatch();
    test_upper_bits();
    test_ctrl();
    test_clear_beat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
